hr_instr_encoder: RTL and testbench

- Sequential program loader that encodes symbolic instruction requests into 32-bit RV64 instruction words and writes them into instruction memory.
- Supports R (add/sub/and/or), load, store and branch, with field layouts bit-exact to what the core's instruction decoder expects.
- Sits between the testbench or debug host and the instruction-memory write port.
- Owns a word-address counter, a valid/ready request handshake, a memory-write handshake and range checking.

---
 rtl/hr_isa_pkg.sv | 47 ++++
 rtl/hr_instr_encode_comb.sv | 54 +++++
 rtl/hr_instr_encoder.sv | 135 +++++++++++++
 tb/tb_hr_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hr_isa_pkg.sv
// Shared ISA constants and enums for the program loader and the core decoder.
package hr_isa_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0000011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    REQ_R      = 2'd0,
    REQ_LOAD   = 2'd1,
    REQ_STORE  = 2'd2,
    REQ_BRANCH = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_req_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_ODD      = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/hr_instr_encode_comb.sv
// Pure combinational request-to-instruction encoder with immediate range checks.
module hr_instr_encode_comb
  import hr_isa_pkg::*;
#(
  parameter logic [2:0] LS_FUNCT3 = 3'b011
) (
  input  req_type_e          req_type,
  input  alu_req_e           req_alu,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [63:0] imm,
  output logic [31:0]        word,
  output err_code_e          err_code
);

  logic [2:0] f3;
  logic [6:0] f7;

  // Build the word for each type; unused fields stay zero. Branch stores imm[12:1].
  always_comb begin
    word     = '0;
    err_code = ERR_NONE;
    f3       = F3_ADD;
    f7       = F7_BASE;
    case (req_type)
      REQ_R: begin
        case (req_alu)
          ALU_ADD: f3 = F3_ADD;
          ALU_SUB: begin f3 = F3_SUB; f7 = F7_SUB; end
          ALU_AND: f3 = F3_AND;
          ALU_OR:  f3 = F3_OR;
          default: f3 = F3_ADD;
        endcase
        word = {f7, rs2, rs1, f3, rd, OPC_R};
      end
      REQ_LOAD: begin
        word = {imm[11:0], rs1, LS_FUNCT3, rd, OPC_I};
        if ((imm < -64'sd2048) || (imm > 64'sd2047)) err_code = ERR_RANGE;
      end
      REQ_STORE: begin
        word = {imm[11:5], rs2, rs1, LS_FUNCT3, imm[4:0], OPC_S};
        if ((imm < -64'sd2048) || (imm > 64'sd2047)) err_code = ERR_RANGE;
      end
      REQ_BRANCH: begin
        word = {imm[12:6], rs2, rs1, F3_BEQ, imm[5:1], OPC_B};
        if (imm[0]) err_code = ERR_ODD;
        else if ((imm < -64'sd4096) || (imm > 64'sd4094)) err_code = ERR_RANGE;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/hr_instr_encoder.sv
// Sequential program loader: accepts symbolic requests, encodes them and
// writes the words to instruction memory through a ready-gated write port.
module hr_instr_encoder
  import hr_isa_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         DEPTH     = 256,
  parameter logic [2:0] LS_FUNCT3 = 3'b011
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_type_i,
  input  logic [1:0]        req_alu_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic signed [63:0] req_imm_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  enc_state_e        state, state_nx;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       word_p1;
  logic [ADDR_W:0]   cnt;
  logic              err;
  err_code_e         code;

  logic [31:0] enc_word;
  err_code_e   enc_err;
  err_code_e   chk_err;
  logic        hs;
  logic        full;

  hr_instr_encode_comb #(
    .LS_FUNCT3 (LS_FUNCT3)
  ) u_encode (
    .req_type (req_type_e'(req_type_i)),
    .req_alu  (alu_req_e'(req_alu_i)),
    .rd       (req_rd_i),
    .rs1      (req_rs1_i),
    .rs2      (req_rs2_i),
    .imm      (req_imm_i),
    .word     (enc_word),
    .err_code (enc_err)
  );

  assign hs      = req_valid_i && (state == ST_RUN);
  assign full    = (cnt == DEPTH_C);
  assign chk_err = full ? ERR_OVERFLOW : enc_err;

  // Next state and state-decoded outputs; a handshake takes priority over finish.
  always_comb begin
    state_nx    = state;
    req_ready_o = 1'b0;
    imem_we_o   = 1'b0;
    done_o      = 1'b0;
    case (state)
      ST_IDLE: if (start_i) state_nx = ST_RUN;
      ST_RUN: begin
        req_ready_o = 1'b1;
        if (hs) begin
          if (chk_err == ERR_NONE) state_nx = ST_WRITE;
        end else if (finish_i) begin
          state_nx = ST_DONE;
        end
      end
      ST_WRITE: begin
        imem_we_o = 1'b1;
        if (imem_ready_i) state_nx = ST_RUN;
      end
      ST_DONE: begin
        done_o   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Word/address capture, counters and sticky error; the address saturates at the last word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_p1 <= '0;
      word_p1 <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      code    <= ERR_NONE;
    end else begin
      if ((state == ST_IDLE) && start_i) begin
        addr_p1 <= '0;
        cnt     <= '0;
        err     <= 1'b0;
        code    <= ERR_NONE;
      end
      if (hs) begin
        if (chk_err == ERR_NONE) begin
          word_p1 <= enc_word;
        end else begin
          err <= 1'b1;
          if (code == ERR_NONE) code <= chk_err;
        end
      end
      if ((state == ST_WRITE) && imem_ready_i) begin
        cnt <= cnt + 1'b1;
        if (addr_p1 != ADDR_LAST) addr_p1 <= addr_p1 + 1'b1;
      end
    end
  end

  assign imem_addr_o  = addr_p1;
  assign imem_wdata_o = word_p1;
  assign count_o      = cnt;
  assign err_o        = err;
  assign err_code_o   = code;

endmodule

// File: tb/tb_hr_instr_encoder.sv
// Directed plus randomized bench for hr_instr_encoder with a field-level reference model.
module tb_hr_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = '0;
  logic [1:0]  req_alu = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic signed [63:0] req_imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [ADDR_W:0] count;
  logic        err;
  logic [1:0]  err_code;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt = 0;
  int m_err = 0;
  int m_code = 0;

  always #5 clk = ~clk;

  hr_instr_encoder #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .LS_FUNCT3 (3'b011)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .finish_i     (finish),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_type_i   (req_type),
    .req_alu_i    (req_alu),
    .req_rd_i     (req_rd),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .req_imm_i    (req_imm),
    .imem_we_o    (imem_we),
    .imem_ready_i (imem_ready),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .count_o      (count),
    .err_o        (err),
    .err_code_o   (err_code),
    .done_o       (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected instruction word built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_word(input int t, input int alu, input int rd,
                                           input int rs1, input int rs2, input longint imm);
    longint w;
    longint f;
    int f3;
    int f7;
    w = 0;
    case (t)
      0: begin
        f3 = (alu == 2) ? 7 : (alu == 3) ? 6 : 0;
        f7 = (alu == 1) ? 32 : 0;
        w = f7 * (2**25) + rs2 * (2**20) + rs1 * (2**15) + f3 * (2**12) + rd * 128 + 51;
      end
      1: w = (imm & 4095) * (2**20) + rs1 * (2**15) + 3 * 4096 + rd * 128 + 3;
      2: w = ((imm >> 5) & 127) * (2**25) + rs2 * (2**20) + rs1 * (2**15) + 3 * 4096
             + (imm & 31) * 128 + 35;
      default: begin
        f = (imm >>> 1) & 4095;
        w = ((f >> 5) & 127) * (2**25) + rs2 * (2**20) + rs1 * (2**15) + (f & 31) * 128 + 99;
      end
    endcase
    return w[31:0];
  endfunction

  function automatic int ref_err(input int t, input longint imm);
    if (t == 3) begin
      if (imm[0]) return 2;
      if (imm < -4096 || imm > 4094) return 1;
    end else if (t == 1 || t == 2) begin
      if (imm < -2048 || imm > 2047) return 1;
    end
    return 0;
  endfunction

  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
    m_cnt = 0; m_err = 0; m_code = 0;
    check("start_ready", req_ready, 1);
    check("start_count", count, 0);
    check("start_err", err, 0);
    check("start_code", err_code, 0);
  endtask

  task automatic finish_session();
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("done_pulse", done, 1);
    check("done_count", count, m_cnt);
    step();
    check("done_low", done, 0);
    check("idle_ready", req_ready, 0);
  endtask

  task automatic send(input int t, input int alu, input int rd, input int rs1, input int rs2,
                      input longint imm, input int stall, input bit fin);
    logic [31:0] w;
    int e;
    w = ref_word(t, alu, rd, rs1, rs2, imm);
    e = (m_cnt == DEPTH) ? 3 : ref_err(t, imm);
    req_type = 2'(t); req_alu = 2'(alu);
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_imm = imm;
    req_valid = 1'b1;
    finish = fin;
    step();
    req_valid = 1'b0;
    finish = 1'b0;
    if (e == 0) begin
      for (int k = 0; k <= stall; k++) begin
        check("wr_we", imem_we, 1);
        check("wr_addr", imem_addr, m_cnt);
        check("wr_data", imem_wdata, w);
        check("wr_ready", req_ready, 0);
        check("wr_done", done, 0);
        if (k == stall) imem_ready = 1'b1;
        step();
      end
      imem_ready = 1'b0;
      m_cnt++;
      check("post_we", imem_we, 0);
      check("post_ready", req_ready, 1);
      check("post_count", count, m_cnt);
      check("post_done", done, 0);
    end else begin
      m_err = 1;
      if (m_code == 0) m_code = e;
      check("err_we", imem_we, 0);
      check("err_ready", req_ready, 1);
      check("err_flag", err, m_err);
      check("err_code", err_code, m_code);
      check("err_count", count, m_cnt);
    end
  endtask

  function automatic longint rand_imm();
    longint tbl[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, -4097};
    int sel;
    sel = $urandom_range(0, 4);
    case (sel)
      0: return longint'($urandom_range(0, 127)) - 64;
      1: return tbl[$urandom_range(0, 9)];
      2: return (longint'($urandom_range(0, 10000)) - 5000) & ~64'sd1;
      3: return {$urandom, $urandom};
      default: return longint'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_we", imem_we, 0);
    check("rst_ready", req_ready, 0);
    check("rst_count", count, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_data", imem_wdata, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();
    check("idle_noready", req_ready, 0);

    // Session 1: single add
    start_session();
    send(0, 0, 3, 1, 2, 0, 0, 0);
    check("add_word", imem_wdata, 32'h002081B3);
    finish_session();

    // Session 2: stalled sub, ld, errors, sd, beq, overflow keeps first code
    start_session();
    send(0, 1, 5, 6, 7, 0, 3, 0);
    check("sub_word", imem_wdata, 32'h407302B3);
    send(1, 0, 4, 2, 0, -8, 0, 0);
    check("ld_word", imem_wdata, 32'hFF813203);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_run_count", count, m_cnt);
    check("start_in_run_ready", req_ready, 1);
    send(3, 0, 0, 1, 2, 3, 0, 0);
    send(1, 0, 4, 2, 0, 4096, 0, 0);
    send(2, 0, 0, 2, 9, 16, 0, 0);
    check("sd_word", imem_wdata, 32'h00913823);
    send(3, 0, 0, 1, 2, -8, 1, 0);
    check("beq_word", imem_wdata, 32'hFE208E63);
    send(0, 0, 1, 1, 1, 0, 0, 0);
    finish_session();

    // Session 3: overflow after DEPTH writes
    start_session();
    for (int i = 0; i < 5; i++) send(0, 0, i + 1, 1, 2, 0, 0, 0);
    check("ovf_code", err_code, 3);
    finish_session();
    step();
    check("done_once", done, 0);

    // Finish coincident with handshake: request wins
    start_session();
    send(0, 3, 8, 9, 10, 0, 1, 1);
    check("coinc_ready", req_ready, 1);

    // Reset during WRITE
    send(0, 2, 1, 1, 1, 0, 0, 0);
    req_type = 2'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("pre_rst_we", imem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("async_we", imem_we, 0);
    check("async_count", count, 0);
    check("async_ready", req_ready, 0);
    check("async_addr", imem_addr, 0);
    step();
    rst = 1'b0;
    m_cnt = 0; m_err = 0; m_code = 0;
    step();
    check("post_rst_idle", req_ready, 0);

    // Randomized sessions
    for (int s = 0; s < 8; s++) begin
      int n;
      start_session();
      n = $urandom_range(2, 7);
      for (int r = 0; r < n; r++) begin
        send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(),
             $urandom_range(0, 2), 1'b0);
      end
      finish_session();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
